// File: rtl/div8_pkg.sv
// Shared definitions for the sequential 8-bit divider.
// Holds the FSM state encoding, the operand width, the iteration count and
// the quotient value reported on divide-by-zero.
package div8_pkg;

    localparam int unsigned DIV8_W     = 8;
    localparam int unsigned DIV8_ITERS = 8;

    localparam logic [DIV8_W-1:0] DIV8_ZERO_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div8_state_e;

endpackage

// File: rtl/div8_step.sv
// One restoring-division iteration (combinational).
// Shifts the next dividend bit into the partial remainder and trial-subtracts
// the divisor.
// Ports:
//   rem_i    current partial remainder
//   q_msb_i  dividend bit being shifted in (MSB of the quotient shift register)
//   dvs_i    divisor
//   rem_o    next partial remainder
//   q_bit_o  quotient bit produced by this iteration
module div8_step
    import div8_pkg::*;
(
    input  logic [DIV8_W-1:0] rem_i,
    input  logic              q_msb_i,
    input  logic [DIV8_W-1:0] dvs_i,
    output logic [DIV8_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [DIV8_W:0]   trial;
    logic [DIV8_W-1:0] diff;
    logic              c_out;

    assign trial = {rem_i, q_msb_i};

    sub8 u_sub8 (
        .a_i     (trial[DIV8_W-1:0]),
        .b_i     (dvs_i),
        .diff_o  (diff),
        .c_out_o (c_out)
    );

    // A set trial[8] means the 9-bit trial exceeds any 8-bit divisor. The
    // 8-bit difference is then still exact mod 256, so it is taken as-is.
    assign q_bit_o = trial[DIV8_W] | c_out;
    assign rem_o   = q_bit_o ? diff : trial[DIV8_W-1:0];

endmodule

// File: rtl/sub8.sv
// Shared ALU 8-bit subtractor: diff = a + ~b + 1.
// Ports:
//   a_i      minuend
//   b_i      subtrahend
//   diff_o   a - b, mod 256
//   c_out_o  carry out; 1 means no borrow (a >= b)
module sub8
    import div8_pkg::*;
(
    input  logic [DIV8_W-1:0] a_i,
    input  logic [DIV8_W-1:0] b_i,
    output logic [DIV8_W-1:0] diff_o,
    output logic              c_out_o
);

    assign {c_out_o, diff_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{DIV8_W{1'b0}}, 1'b1};

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit restoring divider with a start/busy/done handshake.
// One shift-and-trial-subtract per clock; results are valid with the one-cycle
// done pulse and hold until the next accepted start.
// Optional build macro DIV8_SIGNED_EN adds input is_signed for truncating
// two's-complement division with the same latency.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while not busy
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   is_signed    (DIV8_SIGNED_EN only) treat operands as two's complement
//   busy         operation in progress
//   done         one-cycle pulse, results valid
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  set when the divisor was zero; valid with done
module div8_seq
    import div8_pkg::*;
#(
    parameter int unsigned WIDTH = DIV8_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV8_SIGNED_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned   CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div8_state_e       state_q;
    logic [CntW-1:0]   count_q;
    logic [WIDTH-1:0]  q_reg_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  dvs_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  quot_q;
    logic [WIDTH-1:0]  remd_q;
    logic              dbz_q;

    logic [WIDTH-1:0]  step_rem;
    logic              step_bit;
    logic [WIDTH-1:0]  quot_raw;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic [WIDTH-1:0]  quot_fin;
    logic [WIDTH-1:0]  rem_fin;

    div8_step u_step (
        .rem_i   (rem_q),
        .q_msb_i (q_reg_q[WIDTH-1]),
        .dvs_i   (dvs_q),
        .rem_o   (step_rem),
        .q_bit_o (step_bit)
    );

    assign quot_raw = {q_reg_q[WIDTH-2:0], step_bit};

`ifdef DIV8_SIGNED_EN
    localparam logic [WIDTH-1:0] Zero = '0;

    logic             neg_quot_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] dividend_neg;
    logic [WIDTH-1:0] divisor_neg;
    logic [WIDTH-1:0] quot_neg;
    logic [WIDTH-1:0] rem_neg;
    logic             unused_c_dd;
    logic             unused_c_dv;
    logic             unused_c_q;
    logic             unused_c_r;

    // Negation is 0 - x through the shared subtractor.
    sub8 u_neg_dd (.a_i(Zero), .b_i(dividend), .diff_o(dividend_neg), .c_out_o(unused_c_dd));
    sub8 u_neg_dv (.a_i(Zero), .b_i(divisor),  .diff_o(divisor_neg),  .c_out_o(unused_c_dv));
    sub8 u_neg_q  (.a_i(Zero), .b_i(quot_raw), .diff_o(quot_neg),     .c_out_o(unused_c_q));
    sub8 u_neg_r  (.a_i(Zero), .b_i(step_rem), .diff_o(rem_neg),      .c_out_o(unused_c_r));

    // -128 negates to itself, which is its correct unsigned magnitude.
    assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? dividend_neg : dividend;
    assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? divisor_neg  : divisor;
    assign quot_fin     = neg_quot_q ? quot_neg : quot_raw;
    assign rem_fin      = neg_rem_q  ? rem_neg  : step_rem;
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign quot_fin     = quot_raw;
    assign rem_fin      = step_rem;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            count_q <= '0;
            q_reg_q <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV8_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            quot_q  <= DIV8_ZERO_QUOT;
                            remd_q  <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                            q_reg_q <= dividend_mag;
                            rem_q   <= '0;
                            dvs_q   <= divisor_mag;
                            count_q <= '0;
`ifdef DIV8_SIGNED_EN
                            neg_quot_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            neg_rem_q  <= is_signed & dividend[WIDTH-1];
`endif
                        end
                    end
                end
                StRun: begin
                    rem_q   <= step_rem;
                    q_reg_q <= quot_raw;
                    count_q <= count_q + CntW'(1);
                    if (count_q == LastCnt) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quot_q  <= quot_fin;
                        remd_q  <= rem_fin;
                        dbz_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;
    assign div_by_zero = dbz_q;

endmodule
